uart_tx_arbiter: RTL and testbench

//  Shares the single uart_core TX FIFO write port among NUM_REQ byte-stream requesters.

---
 rtl/uart_arb_pkg.sv | 11 +
 rtl/uart_tx_arbiter_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared constants and helpers for the UART TX write-port arbiter.
package uart_arb_pkg;
  localparam int UART_BYTE_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;

  function automatic int id_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping; purely combinational.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;

  // Doubling the vector lets a plain shift act as a rotate by ptr.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IW'(i);
    end
  end

  assign w_sum   = {1'b0, w_off} + {1'b0, ptr};
  assign gnt_idx = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
  assign any     = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter onto the uart_core TX FIFO write port.
// One byte per two cycles at most; stalled or over-long grants are force-released.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_PKT_LEN    = 64
) (
  input  logic                             clk,
  input  logic                             reset_btn,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]               req_last,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [UART_BYTE_W-1:0]           write_data,
  output logic                             write_uart,
  input  logic                             tx_full,
  output logic [id_width(NUM_REQ)-1:0]     grant_id,
  output logic                             busy,
  output logic                             timeout_err
);
  localparam int IW = id_width(NUM_REQ);
  localparam int BW = $clog2(MAX_PKT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [IW-1:0]          r_grant_id;
  logic [IW-1:0]          r_rr_ptr;
  logic [BW-1:0]          r_byte_cnt;
  logic [TW-1:0]          r_idle_cnt;
  logic                   r_busy;
  logic                   r_write_uart;
  logic [UART_BYTE_W-1:0] r_write_data;
  logic                   r_timeout_err;

  logic [IW-1:0]          w_pick;
  logic                   w_any;
  logic                   w_in_xfer;
  logic                   w_rdy;
  logic                   w_sel_vld;
  logic                   w_sel_last;
  logic [UART_BYTE_W-1:0] w_sel_dat;
  logic                   w_acc;
  logic                   w_len_hit;
  logic                   w_idle_hit;
  logic                   w_release;
  logic [IW-1:0]          w_ptr_nxt;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_pick),
    .any     (w_any)
  );

  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_last = 1'b0;
    w_sel_dat  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == IW'(i)) begin
        w_sel_vld  = req_valid[i];
        w_sel_last = req_last[i];
        w_sel_dat  = req_data[i*UART_BYTE_W +: UART_BYTE_W];
      end
    end
  end

  assign w_in_xfer  = (r_state == S_XFER);
  assign w_acc      = w_rdy && w_sel_vld;
  assign w_len_hit  = w_acc && !w_sel_last && (r_byte_cnt == BW'(MAX_PKT_LEN - 1));
  assign w_idle_hit = w_in_xfer && !w_sel_vld && (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_release  = (w_acc && w_sel_last) || w_len_hit || w_idle_hit;
  assign w_ptr_nxt  = (r_grant_id == IW'(NUM_REQ - 1)) ? '0 : r_grant_id + IW'(1);

  always_ff @(posedge clk or posedge reset_btn) begin
    if (reset_btn) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = w_any ? S_XFER : S_IDLE;
      S_XFER:  w_state_nxt = w_release ? S_IDLE : S_XFER;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Blocking while write_uart is high spaces bytes out so the lagging tx_full is honoured.
  always_comb begin
    w_rdy     = w_in_xfer && !tx_full && !r_write_uart;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_rdy && (r_grant_id == IW'(i));
    end
  end

  always_ff @(posedge clk or posedge reset_btn) begin
    if (reset_btn) begin
      r_grant_id    <= '0;
      r_rr_ptr      <= '0;
      r_byte_cnt    <= '0;
      r_idle_cnt    <= '0;
      r_busy        <= 1'b0;
      r_write_uart  <= 1'b0;
      r_write_data  <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_write_uart  <= w_acc;
      r_timeout_err <= w_len_hit || w_idle_hit;
      if (w_acc) r_write_data <= w_sel_dat;

      if (r_state == S_IDLE) begin
        if (w_any) begin
          r_grant_id <= w_pick;
          r_busy     <= 1'b1;
          r_byte_cnt <= '0;
          r_idle_cnt <= '0;
        end
      end else if (w_in_xfer) begin
        if (w_release) begin
          r_busy   <= 1'b0;
          r_rr_ptr <= w_ptr_nxt;
        end
        // tx_full back-pressure with valid high is not idleness, so the count holds.
        if (w_acc) begin
          r_byte_cnt <= r_byte_cnt + BW'(1);
          r_idle_cnt <= '0;
        end else if (!w_sel_vld && !w_idle_hit) begin
          r_idle_cnt <= r_idle_cnt + TW'(1);
        end
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign write_uart  = r_write_uart;
  assign write_data  = r_write_data;
  assign grant_id    = r_grant_id;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a byte scoreboard on the write port.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;
  localparam int ML = 4;

  logic           clk = 1'b0;
  logic           reset_btn = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     write_data;
  logic           write_uart;
  logic           tx_full = 1'b0;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_wr = -10;
  logic [7:0] sb[$];
  int         wr_cyc[$];

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO), .MAX_PKT_LEN(ML)) dut (
    .clk         (clk),
    .reset_btn   (reset_btn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .write_data  (write_data),
    .write_uart  (write_uart),
    .tx_full     (tx_full),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every write must match the scoreboard head and be at least two cycles after the previous one.
  always @(negedge clk) begin
    if (write_uart === 1'b1) begin
      chk("wr_gap", 32'((cyc - last_wr) >= 2), 1);
      last_wr = cyc;
      wr_cyc.push_back(cyc);
      chk("sb_has_entry", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("wr_data", write_data, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int lane, input logic [7:0] d, input logic last);
    req_valid[lane] = 1'b1;
    req_data[lane*8 +: 8] = d;
    req_last[lane] = last;
  endtask

  task automatic drop(input int lane);
    req_valid[lane] = 1'b0;
    req_last[lane]  = 1'b0;
  endtask

  // Returns just after the clock edge on which the lane's byte was taken.
  task automatic wait_acc(input int lane, input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (req_valid[lane] && req_ready[lane]) ok = 1'b1;
      step();
    end
    chk({tag, "_accept"}, 32'(ok), 1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 50 && sb.size() != 0; k++) step();
    chk({tag, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    int k4;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write_uart", write_uart, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_ready", req_ready, 0);
    reset_btn = 1'b0;
    step();

    // Single three-byte packet from requester 0.
    wr_cyc.delete();
    sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h43);
    drive(0, 8'h41, 1'b0);
    @(negedge clk);
    chk("t1_idle_ready", req_ready, 0);
    chk("t1_idle_busy", busy, 0);
    step();
    chk("t1_grant_ready", req_ready, 4'b0001);
    chk("t1_grant_busy", busy, 1);
    chk("t1_grant_id", grant_id, 0);
    wait_acc(0, "t1_b0");
    chk("t1_wr_latency", write_uart, 1);
    drive(0, 8'h42, 1'b0);
    wait_acc(0, "t1_b1");
    drive(0, 8'h43, 1'b1);
    wait_acc(0, "t1_b2");
    chk("t1_busy_drop", busy, 0);
    chk("t1_grant_hold", grant_id, 0);
    drop(0);
    drain("t1");
    chk("t1_wr_count", wr_cyc.size(), 3);
    if (wr_cyc.size() >= 3) begin
      chk("t1_spacing01", wr_cyc[1] - wr_cyc[0], 2);
      chk("t1_spacing12", wr_cyc[2] - wr_cyc[1], 2);
    end

    // Requesters 1 and 2 contend; whole packets, no interleave.
    sb.push_back(8'h11); sb.push_back(8'h12); sb.push_back(8'h21); sb.push_back(8'h22);
    drive(1, 8'h11, 1'b0);
    drive(2, 8'h21, 1'b0);
    wait_acc(1, "t2_r1b0");
    chk("t2_grant1", grant_id, 1);
    drive(1, 8'h12, 1'b1);
    @(negedge clk);
    chk("t2_r2_blocked", req_ready[2], 0);
    wait_acc(1, "t2_r1b1");
    drop(1);
    wait_acc(2, "t2_r2b0");
    chk("t2_grant2", grant_id, 2);
    drive(2, 8'h22, 1'b1);
    wait_acc(2, "t2_r2b1");
    drop(2);
    drain("t2");

    // Pointer should sit at 3: requester 3 wins over 0, then stalls into a timeout.
    sb.push_back(8'h31); sb.push_back(8'h01);
    drive(3, 8'h31, 1'b0);
    drive(0, 8'h01, 1'b1);
    wait_acc(3, "t4_r3");
    chk("t4_grant3", grant_id, 3);
    drop(3);
    k4 = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      k4++;
      if (timeout_err === 1'b1) break;
    end
    chk("t4_timeout_latency", k4, 16);
    chk("t4_busy_released", busy, 0);
    step();
    chk("t4_err_one_cycle", timeout_err, 0);
    chk("t4_regrant_busy", busy, 1);
    chk("t4_regrant_id", grant_id, 0);
    wait_acc(0, "t4_r0");
    drop(0);
    drain("t4");

    // tx_full stall longer than the timeout must neither write nor time out.
    sb.push_back(8'h51); sb.push_back(8'h52); sb.push_back(8'h53);
    drive(0, 8'h51, 1'b0);
    wait_acc(0, "t3_b0");
    drive(0, 8'h52, 1'b0);
    step();
    tx_full = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t3_stall_ready", req_ready, 0);
      chk("t3_stall_write", write_uart, 0);
      chk("t3_stall_no_timeout", timeout_err, 0);
    end
    step();
    tx_full = 1'b0;
    @(negedge clk);
    chk("t3_resume_ready", req_ready, 4'b0001);
    step();
    chk("t3_resume_write", write_uart, 1);
    drive(0, 8'h53, 1'b1);
    wait_acc(0, "t3_b2");
    chk("t3_busy_drop", busy, 0);
    drop(0);
    drain("t3");

    // Over-long packet is cut after MAX_PKT_LEN bytes; requester 1 gets the next grant.
    sb.push_back(8'h61); sb.push_back(8'h62); sb.push_back(8'h63); sb.push_back(8'h64);
    sb.push_back(8'h71);
    drive(0, 8'h61, 1'b0);
    wait_acc(0, "t5_b0");
    drive(1, 8'h71, 1'b1);
    drive(0, 8'h62, 1'b0);
    wait_acc(0, "t5_b1");
    drive(0, 8'h63, 1'b0);
    wait_acc(0, "t5_b2");
    drive(0, 8'h64, 1'b0);
    wait_acc(0, "t5_b3");
    chk("t5_len_release", busy, 0);
    chk("t5_len_err", timeout_err, 1);
    drive(0, 8'h65, 1'b0);
    step();
    chk("t5_regrant_id", grant_id, 1);
    chk("t5_regrant_busy", busy, 1);
    chk("t5_err_one_cycle", timeout_err, 0);
    drop(0);
    wait_acc(1, "t5_r1");
    drop(1);
    drain("t5");

    // Reset right after an accept drops the pending write and clears the pointer.
    drive(2, 8'h81, 1'b0);
    wait_acc(2, "t6_r2");
    reset_btn = 1'b1;
    #1;
    chk("t6_rst_write_uart", write_uart, 0);
    chk("t6_rst_write_data", write_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant_id", grant_id, 0);
    chk("t6_rst_req_ready", req_ready, 0);
    chk("t6_rst_timeout_err", timeout_err, 0);
    step();
    step();
    reset_btn = 1'b0;
    drop(2);
    repeat (4) step();
    sb.push_back(8'h91); sb.push_back(8'h93);
    drive(1, 8'h91, 1'b1);
    drive(3, 8'h93, 1'b1);
    wait_acc(1, "t6_r1");
    chk("t6_ptr_reset_grant", grant_id, 1);
    drop(1);
    wait_acc(3, "t6_r3");
    chk("t6_grant3", grant_id, 3);
    drop(3);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
